// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
//   WB_XLEN   : default result width
//   REG_COUNT : architectural register count (width of pending masks)
//   REG_X0    : hard-wired zero register index
//   wb_req_t  : one register-file write request {rd, data}
//   rd_onehot : one-hot of a destination register, zero for x0
package wb_pkg;

  localparam int unsigned WB_XLEN   = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam logic [4:0]  REG_X0    = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  // x0 never counts as a pending write
  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [4:0] rd);
    return (rd == REG_X0) ? '0 : (REG_COUNT'(1) << rd);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t with occupancy, full and empty flags.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   i_push, i_din       : enqueue request (ignored when full)
//   i_pop               : dequeue head (ignored when empty)
//   o_head              : oldest entry
//   o_full, o_empty     : status flags
//   o_count             : occupancy, 0..DEPTH
//   o_entries, o_valid  : age-ordered view (index 0 = oldest) with valid bits
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  wb_req_t                  i_din,
  input  logic                     i_pop,
  output wb_req_t                  o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output wb_req_t                  o_entries [DEPTH],
  output logic [DEPTH-1:0]         o_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_req_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage and pointers; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Age-ordered view: valid entries are contiguous from the read pointer
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      o_entries[i] = r_mem[r_rd_ptr + AW'(i)];
      o_valid[i]   = (CW'(i) < r_count);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with buffered LSU
// results and drives one registered register-file write per cycle.
// Ports:
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU result handshake (into FIFO)
//   wb_we/wb_addr/wb_data               : registered regfile write port
//   pending_mask                        : queued or in-flight writes per reg
//   fifo_count                          : LSU FIFO occupancy
// Optional macro WB_FWD_EN adds fwd_a/fwd_hit/fwd_data lookup ports.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = WB_XLEN,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [XLEN-1:0]               lsu_data,
  output logic                          wb_we,
  output logic [4:0]                    wb_addr,
  output logic [XLEN-1:0]               wb_data,
  output logic [REG_COUNT-1:0]          pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]                    fwd_a,
  output logic                          fwd_hit,
  output logic [XLEN-1:0]               fwd_data
`endif
);

  wb_req_t                w_alu_req;
  wb_req_t                w_lsu_req;
  wb_req_t                w_head;
  wb_req_t                w_commit;
  wb_req_t                w_entries [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  w_valid;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_sel_fifo;
  logic                   w_sel_alu;
  logic                   w_commit_we;
  logic                   r_we;
  logic [4:0]             r_addr;
  logic [XLEN-1:0]        r_data;

  assign w_alu_req = {alu_rd, alu_data};
  assign w_lsu_req = {lsu_rd, lsu_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (lsu_valid && lsu_ready),
    .i_din     (w_lsu_req),
    .i_pop     (w_sel_fifo),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // A full FIFO takes priority so LSU results cannot starve behind the ALU
  always_comb begin
    w_sel_fifo  = !w_empty && (w_full || !alu_valid);
    w_sel_alu   = alu_valid && !w_full;
    w_commit    = w_sel_fifo ? w_head : w_alu_req;
    w_commit_we = (w_sel_fifo || w_sel_alu) && (w_commit.rd != REG_X0);
  end

  assign alu_ready = !w_full;
  assign lsu_ready = !w_full;

  // Output stage; address/data hold when nothing is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_commit_we;
      if (w_commit_we) begin
        r_addr <= w_commit.rd;
        r_data <= w_commit.data;
      end
    end
  end

  assign wb_we   = r_we;
  assign wb_addr = r_addr;
  assign wb_data = r_data;

  // Pending writes: every queued entry plus the output stage
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (w_valid[i]) pending_mask = pending_mask | rd_onehot(w_entries[i].rd);
    end
    if (r_we) pending_mask = pending_mask | rd_onehot(r_addr);
  end

`ifdef WB_FWD_EN
  // Youngest match wins: output stage first, then FIFO oldest to newest
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (r_we && (r_addr == fwd_a)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_data;
    end
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (w_valid[i] && (w_entries[i].rd == fwd_a)) begin
        fwd_hit  = 1'b1;
        fwd_data = w_entries[i].data;
      end
    end
    if (fwd_a == REG_X0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  // Default build has no forwarding lookup
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned D    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, alu_ready;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid, lsu_ready;
  logic [4:0]        lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [31:0]       pending_mask;
  logic [2:0]        fifo_count;
`ifdef WB_FWD_EN
  logic [4:0]        fwd_a;
  logic              fwd_hit;
  logic [XLEN-1:0]   fwd_data;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
`ifdef WB_FWD_EN
    ,
    .fwd_a        (fwd_a),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        alu_acc, lsu_acc;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0;
    alu_acc = 1'b0; lsu_acc = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs presented at that edge
  task automatic model_update();
    bit   full;
    ent_t c;
    bit   have;
    full    = (q.size() == D);
    alu_acc = alu_valid && !full;
    lsu_acc = lsu_valid && !full;
    have    = 1'b0;
    if (alu_acc) begin
      c.rd = alu_rd; c.data = alu_data; have = 1'b1;
    end else if (q.size() > 0) begin
      c = q.pop_front(); have = 1'b1;
    end
    if (have && c.rd != 5'd0) begin
      m_we = 1'b1; m_addr = c.rd; m_data = c.data;
    end else begin
      m_we = 1'b0;
    end
    if (lsu_acc) begin
      c.rd = lsu_rd; c.data = lsu_data;
      q.push_back(c);
    end
  endtask

  function automatic logic [31:0] exp_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
    if (m_we) m[m_addr] = 1'b1;
    return m;
  endfunction

`ifdef WB_FWD_EN
  task automatic chk_fwd(input logic [4:0] a);
    logic        hit = 1'b0;
    logic [31:0] d   = '0;
    fwd_a = a;
    #1;
    if (m_we && m_addr == a) begin hit = 1'b1; d = m_data; end
    foreach (q[i]) if (q[i].rd == a) begin hit = 1'b1; d = q[i].data; end
    if (a == 5'd0) begin hit = 1'b0; d = '0; end
    chk("fwd_hit", 64'(fwd_hit), 64'(hit));
    if (hit) chk("fwd_data", 64'(fwd_data), 64'(d));
  endtask
`endif

  task automatic check_all();
    chk("wb_we",     64'(wb_we),        64'(m_we));
    chk("wb_addr",   64'(wb_addr),      64'(m_addr));
    chk("wb_data",   64'(wb_data),      64'(m_data));
    chk("count",     64'(fifo_count),   64'(q.size()));
    chk("pending",   64'(pending_mask), 64'(exp_mask()));
    chk("alu_ready", 64'(alu_ready),    64'(q.size() != D));
    chk("lsu_ready", 64'(lsu_ready),    64'(q.size() != D));
`ifdef WB_FWD_EN
    chk_fwd(5'($urandom_range(0, 9)));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
`ifdef WB_FWD_EN
    fwd_a = '0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // ALU only
    set_alu(1, 5'd5, 32'hDEADBEEF);
    cycle();
    chk("alu_we", 64'(wb_we), 64'd1);
    chk("alu_addr", 64'(wb_addr), 64'd5);
    chk("alu_data", 64'(wb_data), 64'hDEADBEEF);
    chk("alu_pend5", 64'(pending_mask[5]), 64'd1);
    set_alu(0, 0, 0);
    cycle();
    chk("alu_pend5_clr", 64'(pending_mask[5]), 64'd0);

    // Contention: ALU wins, LSU follows next cycle
    set_alu(1, 5'd3, 32'h11);
    set_lsu(1, 5'd7, 32'h22);
    cycle();
    chk("cont_addr0", 64'(wb_addr), 64'd3);
    chk("cont_pend7a", 64'(pending_mask[7]), 64'd1);
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    cycle();
    chk("cont_addr1", 64'(wb_addr), 64'd7);
    chk("cont_pend7b", 64'(pending_mask[7]), 64'd1);
    cycle();

    // Fill FIFO behind a continuously valid ALU
    for (int k = 0; k < 4; k++) begin
      set_alu(1, 5'(16 + k), 32'(k));
      set_lsu(1, 5'(10 + k), 32'h100 + 32'(k));
      cycle();
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_lsu_rdy", 64'(lsu_ready), 64'd0);
    chk("full_alu_rdy", 64'(alu_ready), 64'd0);
    set_alu(1, 5'd20, 32'h2020);
    set_lsu(0, 0, 0);
    cycle();
    chk("full_head", 64'(wb_addr), 64'd10);
    chk("full_alu_rdy2", 64'(alu_ready), 64'd1);
    cycle();
    chk("full_alu_resume", 64'(wb_addr), 64'd20);
    set_alu(0, 0, 0);
    repeat (4) cycle();

    // x0 result: occupies a slot, never written
    set_lsu(1, 5'd0, 32'hFFFFFFFF);
    cycle();
    chk("x0_count1", 64'(fifo_count), 64'd1);
    chk("x0_pend", 64'(pending_mask), 64'd0);
    set_lsu(0, 0, 0);
    cycle();
    chk("x0_count0", 64'(fifo_count), 64'd0);
    chk("x0_we", 64'(wb_we), 64'd0);

`ifdef WB_FWD_EN
    // Forwarding returns the youngest of two writes to x9
    set_lsu(1, 5'd9, 32'hA);
    cycle();
    set_lsu(1, 5'd9, 32'hB);
    cycle();
    set_lsu(0, 0, 0);
    fwd_a = 5'd9;
    #1;
    chk("fwd9_hit", 64'(fwd_hit), 64'd1);
    chk("fwd9_data", 64'(fwd_data), 64'hB);
    repeat (3) cycle();
`endif

    // Reset mid-stream with 3 FIFO entries
    for (int k = 0; k < 3; k++) begin
      set_alu(1, 5'(1 + k), 32'h50 + 32'(k));
      set_lsu(1, 5'(24 + k), 32'h60 + 32'(k));
      cycle();
    end
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_pend", 64'(pending_mask), 64'd0);
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Randomized traffic with valid held until accepted
    for (int ph = 0; ph < 4; ph++) begin
      int pa, pl;
      pa = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 60 : 10;
      pl = (ph == 0) ? 80 : (ph == 1) ? 90 : (ph == 2) ? 40 : 70;
      for (int n = 0; n < 600; n++) begin
        if (!alu_valid || alu_acc)
          set_alu(1'($urandom_range(0, 99) < pa), 5'($urandom_range(0, 7)), $urandom);
        if (!lsu_valid || lsu_acc)
          set_lsu(1'($urandom_range(0, 99) < pl), 5'($urandom_range(0, 7)), $urandom);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
